// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 serial NOR flash responder with a small
// byte array, status register, page program and sector/bulk erase.
module spi_flash_responder #(
   parameter int C_MEM_ADDR_BITS = 8,
   parameter int C_BUSY_CLK_NUM  = 100
) (
   input  logic       SYS_CLK_I,
   input  logic       SYS_RST_I,
   input  logic       FLASH_CLK_I,
   input  logic       FLASH_CS_I,
   input  logic       FLASH_D0_I,
   output logic       FLASH_D1_O,
   input  logic       FLASH_WP_I,
   output logic [7:0] CMD_O,
   output logic       CMD_VALID_O,
   output logic       WIP_O,
   output logic       WEL_O
);

   localparam int AW        = C_MEM_ADDR_BITS;
   localparam int MEM_SIZE  = 2 ** AW;
   localparam int BUSY_LOAD = (C_BUSY_CLK_NUM > MEM_SIZE) ?
                              C_BUSY_CLK_NUM : MEM_SIZE;
   localparam int PAGE_BITS = (AW < 8) ? AW : 8;
   localparam int SW        = (AW > 8) ? AW : 8;

   localparam logic [16:0]          BUSY_INIT = 17'(BUSY_LOAD);
   localparam logic [16:0]          BUSY_ONE  = 17'd1;
   localparam logic [AW-1:0]        A_ONE     = 1;
   localparam logic [PAGE_BITS-1:0] P_ONE     = 1;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_SE   = 8'h20;
   localparam logic [7:0] OP_BE   = 8'hC7;

   typedef enum logic [2:0] {
      IDLE, OPCODE, ADDR, DATA_IN, DATA_OUT, IGNORE
   } state_t;

   typedef enum logic [2:0] {
      K_NONE, K_RDSR, K_READ, K_PP, K_SE, K_BE
   } op_t;

   logic cs_s1, cs_s2, cs_d;
   logic sck_s1, sck_s2, sck_d;
   logic d0_s1, d0_s2;
   logic cs_rise, cs_fall, sck_rise, sck_fall;

   state_t state, state_nxt;
   op_t    op, op_nxt;

   logic [4:0]    bit_cnt;
   logic [SW-2:0] shift;
   logic [SW-1:0] rx_word;
   logic [7:0]    rx_byte;
   logic [AW-1:0] addr, addr_pinc;
   logic          op_ok, pp_wrote, addr_done;
   logic [7:0]    out_shift, nxt_byte;
   logic [2:0]    out_cnt;
   logic          d1;
   logic [7:0]    cmd;
   logic          cmd_valid, cmd_acc;
   logic          wel, wip, wel_set, wel_clr;
   logic [16:0]   busy_cnt;
   logic          erase_en;
   logic [AW-1:0] erase_ptr;
   logic          byte_done, addr_last;
   logic          start_busy, start_erase, busy_done, pp_we;

   logic [7:0] mem [MEM_SIZE];

   assign cs_rise  = cs_s2 & ~cs_d;
   assign cs_fall  = ~cs_s2 & cs_d;
   assign sck_rise = sck_s2 & ~sck_d;
   assign sck_fall = ~sck_s2 & sck_d;

   assign rx_word   = {shift, d0_s2};
   assign rx_byte   = rx_word[7:0];
   assign byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
   assign addr_last = sck_rise && (bit_cnt == 5'd23);

   assign nxt_byte = (op == K_RDSR) ? {6'b0, wel, wip} : mem[addr];

   // Busy/erase only start from a whole-byte boundary of a permitted op.
   assign start_busy = cs_rise && (bit_cnt == 5'd0) &&
                       ((op == K_PP && pp_wrote) ||
                        (op_ok && op == K_SE && addr_done) ||
                        (op_ok && op == K_BE));
   assign start_erase = start_busy && (op != K_PP);
   assign busy_done   = !start_busy && (busy_cnt == BUSY_ONE);
   assign pp_we       = (state == DATA_IN) && byte_done &&
                        op_ok && !cs_rise;

   always_comb begin
      addr_pinc = addr;
      addr_pinc[PAGE_BITS-1:0] = addr[PAGE_BITS-1:0] + P_ONE;
   end

   always_comb begin
      state_nxt = state;
      op_nxt    = op;
      cmd_acc   = 1'b0;
      wel_set   = 1'b0;
      wel_clr   = 1'b0;
      if (state == OPCODE && byte_done) begin
         state_nxt = IGNORE;
         op_nxt    = K_NONE;
         if (!wip || rx_byte == OP_RDSR) begin
            cmd_acc = 1'b1;
            unique case (1'b1)
               rx_byte == OP_WREN: wel_set = 1'b1;
               rx_byte == OP_WRDI: wel_clr = 1'b1;
               rx_byte == OP_RDSR: begin
                  state_nxt = DATA_OUT;
                  op_nxt    = K_RDSR;
               end
               rx_byte == OP_READ: begin
                  state_nxt = ADDR;
                  op_nxt    = K_READ;
               end
               rx_byte == OP_PP: begin
                  state_nxt = ADDR;
                  op_nxt    = K_PP;
               end
               rx_byte == OP_SE: begin
                  state_nxt = ADDR;
                  op_nxt    = K_SE;
               end
               rx_byte == OP_BE: op_nxt = K_BE;
               default: cmd_acc = 1'b0;
            endcase
         end
      end
      if (state == ADDR && addr_last) begin
         if (op == K_READ)
            state_nxt = DATA_OUT;
         else if (op == K_PP)
            state_nxt = DATA_IN;
         else
            state_nxt = IGNORE;
      end
      if (cs_fall) begin
         state_nxt = OPCODE;
         op_nxt    = K_NONE;
      end
      if (cs_rise) begin
         state_nxt = IDLE;
         op_nxt    = K_NONE;
      end
   end

   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         state <= IDLE;
         op    <= K_NONE;
      end else begin
         state <= state_nxt;
         op    <= op_nxt;
      end
   end

   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         cs_s1  <= 1'b1;
         cs_s2  <= 1'b1;
         cs_d   <= 1'b1;
         sck_s1 <= 1'b0;
         sck_s2 <= 1'b0;
         sck_d  <= 1'b0;
         d0_s1  <= 1'b0;
         d0_s2  <= 1'b0;
      end else begin
         cs_s1  <= FLASH_CS_I;
         cs_s2  <= cs_s1;
         cs_d   <= cs_s2;
         sck_s1 <= FLASH_CLK_I;
         sck_s2 <= sck_s1;
         sck_d  <= sck_s2;
         d0_s1  <= FLASH_D0_I;
         d0_s2  <= d0_s1;
      end
   end

   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         bit_cnt   <= '0;
         shift     <= '0;
         addr      <= '0;
         op_ok     <= 1'b0;
         pp_wrote  <= 1'b0;
         addr_done <= 1'b0;
         out_shift <= '0;
         out_cnt   <= '0;
         d1        <= 1'b0;
         cmd       <= '0;
         cmd_valid <= 1'b0;
      end else begin
         cmd_valid <= cmd_acc;
         if (cmd_acc) begin
            cmd   <= rx_byte;
            op_ok <= wel & FLASH_WP_I;
         end
         if (sck_rise)
            shift <= rx_word[SW-2:0];
         if (cs_fall) begin
            bit_cnt   <= '0;
            pp_wrote  <= 1'b0;
            addr_done <= 1'b0;
            out_cnt   <= '0;
            d1        <= 1'b0;
         end else if (cs_rise) begin
            d1 <= 1'b0;
         end else if (sck_rise) begin
            if (state == OPCODE) begin
               bit_cnt <= byte_done ? 5'd0 : bit_cnt + 5'd1;
            end else if (state == ADDR) begin
               if (addr_last) begin
                  bit_cnt   <= '0;
                  addr      <= rx_word[AW-1:0];
                  addr_done <= 1'b1;
                  out_cnt   <= '0;
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end else if (state == DATA_IN || state == IGNORE) begin
               bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
               if (state == DATA_IN && byte_done) begin
                  addr <= addr_pinc;
                  if (op_ok)
                     pp_wrote <= 1'b1;
               end
            end
         end else if (sck_fall && state == DATA_OUT) begin
            // Next byte is fetched on the first falling edge of each byte.
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd0) begin
               d1        <= nxt_byte[7];
               out_shift <= {nxt_byte[6:0], 1'b0};
               if (op == K_READ)
                  addr <= addr + A_ONE;
            end else begin
               d1        <= out_shift[7];
               out_shift <= {out_shift[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge SYS_CLK_I or posedge SYS_RST_I) begin
      if (SYS_RST_I) begin
         wip       <= 1'b0;
         wel       <= 1'b0;
         busy_cnt  <= '0;
         erase_en  <= 1'b0;
         erase_ptr <= '0;
      end else begin
         if (start_busy) begin
            wip      <= 1'b1;
            busy_cnt <= BUSY_INIT;
         end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - BUSY_ONE;
            if (busy_done)
               wip <= 1'b0;
         end
         if (busy_done)
            wel <= 1'b0;
         else if (wel_set)
            wel <= 1'b1;
         else if (wel_clr)
            wel <= 1'b0;
         if (start_erase) begin
            erase_en  <= 1'b1;
            erase_ptr <= '0;
         end else if (erase_en) begin
            erase_ptr <= erase_ptr + A_ONE;
            if (&erase_ptr)
               erase_en <= 1'b0;
         end
      end
   end

   // Array has no reset: contents survive reset and are set up by erase.
   always_ff @(posedge SYS_CLK_I) begin
      if (erase_en)
         mem[erase_ptr] <= 8'hFF;
      else if (pp_we)
         mem[addr] <= mem[addr] & rx_byte;
   end

   assign FLASH_D1_O  = d1;
   assign CMD_O       = cmd;
   assign CMD_VALID_O = cmd_valid;
   assign WIP_O       = wip;
   assign WEL_O       = wel;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI transactions against the flash
// responder, with queued expectations for read bytes and opcode pulses.
module tb_spi_flash_responder;

   localparam int HALF = 8;
   localparam int GAP  = 10;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       sck  = 1'b0;
   logic       cs   = 1'b1;
   logic       mosi = 1'b0;
   logic       wp   = 1'b1;
   logic       miso;
   logic [7:0] cmd;
   logic       cmd_v;
   logic       wip;
   logic       wel;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_cmd[$];
   logic       rx_vld = 1'b0;
   logic [7:0] rx_data = 8'h00;

   always #5 clk = ~clk;

   spi_flash_responder #(
      .C_MEM_ADDR_BITS(8),
      .C_BUSY_CLK_NUM (1000)
   ) dut (
      .SYS_CLK_I  (clk),
      .SYS_RST_I  (rst),
      .FLASH_CLK_I(sck),
      .FLASH_CS_I (cs),
      .FLASH_D0_I (mosi),
      .FLASH_D1_O (miso),
      .FLASH_WP_I (wp),
      .CMD_O      (cmd),
      .CMD_VALID_O(cmd_v),
      .WIP_O      (wip),
      .WEL_O      (wel)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rx_vld) begin
         n_vec++;
         if (exp_rx.size() == 0) begin
            n_err++;
            $display("FAIL rx_byte: got %02h, expected none", rx_data);
         end else begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            if (rx_data !== e) begin
               n_err++;
               $display("FAIL rx_byte: got %02h, expected %02h", rx_data, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmd_v === 1'b1) begin
         n_vec++;
         if (exp_cmd.size() == 0) begin
            n_err++;
            $display("FAIL cmd_pulse: got %02h, expected no pulse", cmd);
         end else begin
            logic [7:0] e;
            e = exp_cmd.pop_front();
            if (cmd !== e) begin
               n_err++;
               $display("FAIL cmd_pulse: got %02h, expected %02h", cmd, e);
            end
         end
      end
   end

   task automatic xfer(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         repeat (HALF) @(negedge clk);
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic rd_byte(input logic [7:0] e);
      logic [7:0] r;
      exp_rx.push_back(e);
      mosi = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         repeat (HALF) @(negedge clk);
         r[i] = miso;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      rx_data = r;
      rx_vld  = 1'b1;
      @(negedge clk);
      rx_vld  = 1'b0;
   endtask

   task automatic cs_lo();
      @(negedge clk);
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_hi();
      repeat (HALF) @(negedge clk);
      cs = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic op(input logic [7:0] c, input bit acc);
      if (acc)
         exp_cmd.push_back(c);
      xfer({24'h0, c}, 8);
   endtask

   task automatic simple(input logic [7:0] c, input bit acc);
      cs_lo();
      op(c, acc);
      cs_hi();
   endtask

   task automatic rdsr(input logic [7:0] e);
      cs_lo();
      op(8'h05, 1'b1);
      rd_byte(e);
      cs_hi();
   endtask

   task automatic read2(input logic [23:0] a, input logic [7:0] e0,
                        input logic [7:0] e1);
      cs_lo();
      op(8'h03, 1'b1);
      xfer({8'h0, a}, 24);
      rd_byte(e0);
      rd_byte(e1);
      cs_hi();
   endtask

   task automatic pp2(input logic [23:0] a, input logic [7:0] b0,
                      input logic [7:0] b1);
      cs_lo();
      op(8'h02, 1'b1);
      xfer({8'h0, a}, 24);
      xfer({24'h0, b0}, 8);
      xfer({24'h0, b1}, 8);
      cs_hi();
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (wip === 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("wip_clear_timeout", {31'h0, wip}, 32'h0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ones;
      repeat (4) @(negedge clk);
      chk("rst_miso", {31'h0, miso}, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_cmd", {24'h0, cmd}, 32'h0);
      chk("rst_cmd_valid", {31'h0, cmd_v}, 32'h0);
      chk("rst_wip", {31'h0, wip}, 32'h0);
      chk("rst_wel", {31'h0, wel}, 32'h0);

      // WREN then RDSR
      simple(8'h06, 1'b1);
      rdsr(8'h02);
      chk("wren_wel", {31'h0, wel}, 32'h1);

      // bulk erase, status while busy and after, read back
      simple(8'h06, 1'b1);
      simple(8'hC7, 1'b1);
      chk("be_wip", {31'h0, wip}, 32'h1);
      rdsr(8'h03);
      wait_idle();
      chk("be_wel_clr", {31'h0, wel}, 32'h0);
      rdsr(8'h00);
      read2(24'hFF0000, 8'hFF, 8'hFF);

      // page program; WRDI while busy is ignored
      simple(8'h06, 1'b1);
      pp2(24'hFF0000, 8'hAA, 8'hBB);
      chk("pp_wip", {31'h0, wip}, 32'h1);
      rdsr(8'h03);
      simple(8'h04, 1'b0);
      chk("busy_wrdi_ignored", {31'h0, wel}, 32'h1);
      wait_idle();
      chk("pp_wel_clr", {31'h0, wel}, 32'h0);
      read2(24'hFF0000, 8'hAA, 8'hBB);

      // program without WEL is discarded
      cs_lo();
      op(8'h02, 1'b1);
      xfer(32'h000010, 24);
      xfer(32'h55, 8);
      cs_hi();
      chk("pp_nowel_wip", {31'h0, wip}, 32'h0);
      read2(24'h000010, 8'hFF, 8'hFF);

      // sector erase cut short after 13 address bits
      simple(8'h06, 1'b1);
      cs_lo();
      op(8'h20, 1'b1);
      xfer(32'h0, 13);
      cs_hi();
      chk("se_short_wip", {31'h0, wip}, 32'h0);
      chk("se_short_wel", {31'h0, wel}, 32'h1);
      read2(24'h000000, 8'hAA, 8'hBB);
      simple(8'h04, 1'b1);
      chk("wrdi_wel", {31'h0, wel}, 32'h0);

      // unknown opcode: no pulse, last command retained
      simple(8'h9F, 1'b0);
      chk("unknown_cmd_kept", {24'h0, cmd}, 32'h04);

      // program across page wrap: 0xFF then 0x00 (0xAA & 0x34 = 0x20)
      simple(8'h06, 1'b1);
      pp2(24'h0000FF, 8'h12, 8'h34);
      wait_idle();
      read2(24'h0000FF, 8'h12, 8'h20);

      // reset in the middle of a read byte (0xBB, bit 4 on the line)
      cs_lo();
      op(8'h03, 1'b1);
      xfer(32'h000001, 24);
      xfer(32'h0, 3);
      repeat (4) @(negedge clk);
      chk("mid_read_miso", {31'h0, miso}, 32'h1);
      rst = 1'b1;
      #1;
      chk("reset_miso", {31'h0, miso}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      ones = 1'b0;
      mosi = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (HALF) @(negedge clk);
         ones = ones | miso;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      chk("post_reset_miso", {31'h0, ones}, 32'h0);
      cs_hi();
      rdsr(8'h00);
      read2(24'h000001, 8'hBB, 8'hFF);

      repeat (10) @(negedge clk);
      chk("rx_queue_drained", exp_rx.size(), 32'h0);
      chk("cmd_queue_drained", exp_cmd.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
